// File: rtl/pipe_sel_mux.sv
// N:1 selector into a single output register; explicit select (MODE 0) or round-robin (MODE 1).
// Latency: 1 cycle from input handshake to out_valid.
// Backpressure: in_ready only while the register is empty or draining this cycle.
module pipe_sel_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic             can_load;
  logic             sel_ok;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_dat;
  logic             grant_vin;
  logic             xfer;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic [SEL_W:0]   rr_sum;
  logic [SEL_W-1:0] rr_idx;

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign can_load = rst_n && (!out_valid || out_ready);

  generate
    if ((1 << SEL_W) == NUM_IN) begin : g_sel_pow2
      assign sel_ok = 1'b1;
    end else begin : g_sel_range
      assign sel_ok = (int'(sel) < NUM_IN);
    end
  endgenerate

  // First valid input at or after ptr, wrapping modulo NUM_IN.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      rr_sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (rr_sum >= (SEL_W+1)'(NUM_IN)) begin
        rr_sum = rr_sum - (SEL_W+1)'(NUM_IN);
      end
      rr_idx = rr_sum[SEL_W-1:0];
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  always_comb begin
    if (MODE == 0) begin
      grant     = sel;
      grant_vld = sel_ok;
    end else begin
      grant     = rr_grant;
      grant_vld = rr_found;
    end
  end

  always_comb begin
    in_ready  = '0;
    grant_dat = '0;
    grant_vin = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = can_load && grant_vld;
        grant_dat   = in_data[i*WIDTH +: WIDTH];
        grant_vin   = in_valid[i];
      end
    end
  end

  assign xfer = can_load && grant_vld && grant_vin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_dat;
        out_src   <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // The pointer only moves on an accepted word, so stalls never skip a requester.
      if (xfer && (MODE != 0)) begin
        ptr <= (grant == SEL_W'(NUM_IN-1)) ? '0 : grant + 1'b1;
      end
      if ((MODE == 0) && can_load && !sel_ok) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Drives three pipe_sel_mux instances (MODE 0 x4, MODE 0 x3, MODE 1 x4) from shared stimulus
// and compares each against a cycle-level reference model built from the handshake rules.
module tb_pipe_sel_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d [4];
  logic [3:0]  v;
  logic [1:0]  sel;
  logic        ordy;
  logic [127:0] din;

  logic [3:0]  a_rdy;  logic [31:0] a_dat;  logic [1:0] a_src;  logic a_vld;  logic a_err;
  logic [2:0]  b_rdy;  logic [31:0] b_dat;  logic [1:0] b_src;  logic b_vld;  logic b_err;
  logic [3:0]  c_rdy;  logic [31:0] c_dat;  logic [1:0] c_src;  logic c_vld;  logic c_err;

  logic [3:0]  o_rdy [3];
  logic [31:0] o_dat [3];
  logic [1:0]  o_src [3];
  logic        o_vld [3];
  logic        o_err [3];

  always #5 clk = ~clk;

  assign din = {d[3], d[2], d[1], d[0]};

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(4), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(v), .in_ready(a_rdy), .sel(sel),
    .out_data(a_dat), .out_src(a_src), .out_valid(a_vld), .out_ready(ordy), .sel_err(a_err));

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(3), .MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(din[95:0]), .in_valid(v[2:0]), .in_ready(b_rdy), .sel(sel),
    .out_data(b_dat), .out_src(b_src), .out_valid(b_vld), .out_ready(ordy), .sel_err(b_err));

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(4), .MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(v), .in_ready(c_rdy), .sel(sel),
    .out_data(c_dat), .out_src(c_src), .out_valid(c_vld), .out_ready(ordy), .sel_err(c_err));

  assign o_rdy[0] = a_rdy;          assign o_rdy[1] = {1'b0, b_rdy};  assign o_rdy[2] = c_rdy;
  assign o_dat[0] = a_dat;          assign o_dat[1] = b_dat;          assign o_dat[2] = c_dat;
  assign o_src[0] = a_src;          assign o_src[1] = b_src;          assign o_src[2] = c_src;
  assign o_vld[0] = a_vld;          assign o_vld[1] = b_vld;          assign o_vld[2] = c_vld;
  assign o_err[0] = a_err;          assign o_err[1] = b_err;          assign o_err[2] = c_err;

  int n_of    [3] = '{4, 3, 4};
  int mode_of [3] = '{0, 0, 1};

  bit          m_v   [3];
  logic [31:0] m_d   [3];
  int          m_s   [3];
  int          m_ptr [3];
  bit          m_err [3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_grant(input int k, output bit found, output int g);
    found = 1'b0;
    g = 0;
    if (mode_of[k] == 0) begin
      found = (int'(sel) < n_of[k]);
      g = int'(sel);
    end else begin
      for (int j = 0; j < n_of[k]; j++) begin
        int idx;
        idx = (m_ptr[k] + j) % n_of[k];
        if (!found && v[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
    end
  endfunction

  function automatic bit model_canload(input int k);
    return rst_n && (!m_v[k] || ordy);
  endfunction

  function automatic logic [3:0] model_ready(input int k);
    bit found;
    int g;
    model_grant(k, found, g);
    if (model_canload(k) && found) return 4'(1 << g);
    return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 1'b0; m_d[k] = '0; m_s[k] = 0; m_ptr[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      bit found;
      int g;
      bit cl;
      model_grant(k, found, g);
      cl = model_canload(k);
      if (mode_of[k] == 0 && cl && int'(sel) >= n_of[k]) m_err[k] = 1'b1;
      if (cl && found && v[g]) begin
        m_d[k] = d[g];
        m_s[k] = g;
        m_v[k] = 1'b1;
        if (mode_of[k] == 1) m_ptr[k] = (g + 1) % n_of[k];
      end else if (ordy) begin
        m_v[k] = 1'b0;
      end
    end
  endtask

  task automatic check_ready();
    for (int k = 0; k < 3; k++) chk($sformatf("rdy%0d", k), 32'(o_rdy[k]), 32'(model_ready(k)));
  endtask

  task automatic check_out();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("vld%0d", k), 32'(o_vld[k]), 32'(m_v[k]));
      chk($sformatf("dat%0d", k), o_dat[k], m_d[k]);
      chk($sformatf("src%0d", k), 32'(o_src[k]), 32'(m_s[k]));
      chk($sformatf("err%0d", k), 32'(o_err[k]), 32'(m_err[k]));
    end
  endtask

  // Inputs are set ~1ns after an edge; ready is checked before the next edge, outputs 1ns after it.
  task automatic tick();
    #1;
    check_ready();
    @(posedge clk);
    model_edge();
    #1;
    check_out();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    v = 4'b1111; sel = 2'd2; ordy = 1'b1;
    model_reset();

    repeat (3) tick();
    chk("rst_a_rdy", 32'(a_rdy), 32'h0);
    chk("rst_a_vld", 32'(a_vld), 32'h0);
    chk("rst_a_dat", a_dat, 32'h0);

    rst_n = 1'b1;
    #1;
    chk("rel_a_rdy", 32'(a_rdy), 32'h4);
    tick();
    chk("rel_a_dat", a_dat, d[2]);

    v = 4'b0000; ordy = 1'b1;
    tick();

    sel = 2'd1; d[1] = 32'hA5A5_0001; v = 4'b0010; ordy = 1'b0;
    tick();
    chk("bp_vld", 32'(a_vld), 32'h1);
    chk("bp_dat", a_dat, 32'hA5A5_0001);
    chk("bp_rdy", 32'(a_rdy), 32'h0);
    d[1] = 32'h0000_0002;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", a_dat, 32'hA5A5_0001);
    end
    ordy = 1'b1;
    tick();
    chk("bp_refill_dat", a_dat, 32'h0000_0002);
    chk("bp_refill_vld", 32'(a_vld), 32'h1);

    sel = 2'd3; v = 4'b1000;
    for (int w = 1; w <= 8; w++) begin
      d[3] = 32'(w);
      tick();
      chk("stream_dat", a_dat, 32'(w));
      chk("stream_src", 32'(a_src), 32'd3);
    end

    async_reset();
    chk("inv_err_clear", 32'(b_err), 32'h0);
    sel = 2'd3; v = 4'b0111; ordy = 1'b1;
    #1;
    chk("inv_rdy", 32'(b_rdy), 32'h0);
    tick();
    chk("inv_err_set", 32'(b_err), 32'h1);
    chk("inv_no_xfer", 32'(b_vld), 32'h0);
    sel = 2'd0;
    tick();
    chk("inv_err_sticky", 32'(b_err), 32'h1);
    async_reset();
    chk("inv_err_reset", 32'(b_err), 32'h0);

    v = 4'b1111; ordy = 1'b1; sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_all", 32'(c_src), 32'(i % 4));
    end
    v = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_odd", 32'(c_src), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    ordy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_stall_src", 32'(c_src), 32'd3);
      chk("rr_stall_vld", 32'(c_vld), 32'h1);
    end
    ordy = 1'b1;
    tick();
    chk("rr_resume1", 32'(c_src), 32'd1);
    tick();
    chk("rr_resume3", 32'(c_src), 32'd3);

    ordy = 1'b0;
    tick();
    async_reset();
    chk("mid_rst_a_vld", 32'(a_vld), 32'h0);
    chk("mid_rst_c_vld", 32'(c_vld), 32'h0);
    v = 4'b1111; ordy = 1'b1;
    tick();
    chk("mid_rst_first", 32'(c_src), 32'd0);
    chk("mid_rst_c_vld1", 32'(c_vld), 32'h1);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      v    = 4'($urandom);
      sel  = 2'($urandom_range(0, 3));
      ordy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) async_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_sel_mux.md
Name: pipe_sel_mux

Overview:
Parametrised N:1 data selector with a registered output stage and valid/ready handshakes on every input and on the output. It replaces fixed 3-input combinational selects, such as the writeback-source and destination-register selects, wherever the source can stall. Two modes are supported. MODE 0 steers by an explicit select. MODE 1 arbitrates round-robin among valid inputs and reports the winning source.

Parameters:
WIDTH, 32, data width per input (1..64)
NUM_IN, 4, number of inputs (2..16)
SEL_W, $clog2(NUM_IN), select/source index width (derived; do not override)
MODE, 0, 0 = explicit select via sel; 1 = round-robin arbitration (sel ignored)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_IN*WIDTH  packed inputs; input i occupies [i*WIDTH +: WIDTH]
in_valid  input  NUM_IN  per-input valid
in_ready  output  NUM_IN  per-input ready (combinational)
sel  input  SEL_W  explicit select (MODE 0 only)
out_data  output  WIDTH  registered selected data
out_src  output  SEL_W  registered index of the input that supplied out_data
out_valid  output  1  output register holds data
out_ready  input  1  downstream accepts
sel_err  output  1  sticky flag: sel >= NUM_IN was presented while the output stage could load (MODE 0)

Behaviour:
- Reset (asynchronous, rst_n=0): out_valid=0, out_data=0, out_src=0, sel_err=0, rr pointer=0. Reset while out_valid=1 discards the held word; no handshake completes.
- can_load = !out_valid || out_ready. A full register that is drained and refilled in the same cycle gives 1 word/cycle throughput.
- Grant selection:
  - MODE 0: grant = sel when sel < NUM_IN.
  - MODE 1: grant = first i with in_valid[i], scanning ptr, ptr+1, … wrapping modulo NUM_IN.
  - If nothing is valid, there is no grant.
- in_ready[i] = can_load && (i == grant). All other inputs see 0. in_ready never depends on the in_valid of the same channel in MODE 0.
- Transfer on input i: in_valid[i] && in_ready[i] at a rising edge. At that edge, out_data <= in_data[i], out_src <= i, out_valid <= 1.
- No transfer but out_ready && out_valid: out_valid <= 0. out_data and out_src hold their last values.
- Stability: while out_valid && !out_ready, out_data and out_src do not change.
- Latency: input accepted at edge N is visible on out_* after edge N, i.e. 1 cycle.
- Round-robin pointer (MODE 1): on a transfer from i, ptr <= (i+1) mod NUM_IN, with wrap at NUM_IN-1 → 0. Otherwise ptr holds. A stall never advances ptr.
- MODE 0 invalid select: when sel >= NUM_IN (possible only when NUM_IN is not a power of 2), all in_ready are 0. sel_err is set when can_load=1 and stays set until reset. out_* behave as if nothing is valid.
- Non-selected inputs may change freely without effect. An input holding valid while not granted loses nothing.
- MODE 1 simultaneous valids: exactly one grant per cycle, so no input starves longer than NUM_IN-1 transfers.
- sel_err is tied 0 in MODE 1.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with in_valid=4'b1111 → out_valid=0, out_data=0, all in_ready=0 during reset; after release (MODE 0, sel=2, out_ready=1), in_ready=4'b0100 and out_data=in_data[2] one cycle later.
- MODE 0 backpressure: sel=1, in_data[1]=32'hA5A5_0001, out_ready=0 → word captured, out_valid=1, in_ready=0. Change in_data[1] to 32'h0000_0002 for 5 cycles → out_data stays A5A5_0001. Raise out_ready → 0002 loads on the same edge the first word drains.
- MODE 0 streaming: sel fixed at 3, 8 back-to-back words 1..8 with out_ready=1 → out_data sequence 1..8 on consecutive cycles, out_src=3 throughout.
- Invalid select: NUM_IN=3, sel=2'b11, in_valid=3'b111 → in_ready=0, no transfer, sel_err=1 and stays 1 after sel returns to 0, until rst_n pulse.
- MODE 1 fairness: NUM_IN=4, all valid continuously, out_ready=1 → out_src sequence 0,1,2,3,0,1. With only inputs 1 and 3 valid → 1,3,1,3. out_ready=0 for 4 cycles mid-sequence → ptr unchanged and the sequence resumes without skipping.
- Reset mid-operation: out_valid=1, out_ready=0, assert rst_n=0 asynchronously between edges → out_valid drops immediately. After release in MODE 1, the first grant goes to input 0 (ptr=0).
